// File: rtl/osiris_wb_pkg.sv
// Shared Wishbone responder definitions: FSM encoding, bus address width and
// the address decode check.
package osiris_wb_pkg;

   localparam int unsigned WB_ADR_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } wb_state_e;

   // A byte address is only legal when it is word aligned and lands inside the array.
   function automatic logic adr_decode_err(input logic [WB_ADR_W-1:0] adr,
                                           input int unsigned         addr_width);
      logic [WB_ADR_W-1:0] hi;
      hi = adr >> (addr_width + 2);
      return (adr[1:0] != 2'b00) || (hi != '0);
   endfunction

endpackage

// File: rtl/wbs_sram_responder_if.sv
// Wishbone classic-cycle bus between a master and the SRAM responder.
interface wbs_sram_responder_if
   import osiris_wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
);

   logic                    wb_cyc_i;
   logic                    wb_stb_i;
   logic                    wb_we_i;
   logic [WB_ADR_W-1:0]     wb_adr_i;
   logic [DATA_WIDTH/8-1:0] wb_sel_i;
   logic [DATA_WIDTH-1:0]   wb_dat_i;
   logic [DATA_WIDTH-1:0]   wb_dat_o;
   logic                    wb_ack_o;
   logic                    wb_err_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );

endinterface

// File: rtl/sram_1rw.sv
// Single-port synchronous SRAM with per-byte write enables and a registered
// read port; contents are never reset.
module sram_1rw #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic                    we,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // rdata only moves on a read, so it holds the last word read across writes.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
               if (be[b]) begin
                  mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/wbs_sram_responder.sv
// Wishbone classic slave in front of a word SRAM: one ack/err pulse per cycle,
// optional wait states, byte-lane writes, decode errors on bad addresses.
module wbs_sram_responder
   import osiris_wb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic                 clk,
   input logic                 rst,
   wbs_sram_responder_if.slave wb
);

   localparam int unsigned SEL_W    = DATA_WIDTH / 8;
   localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   wb_state_e             state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  req, accept, fire;

   logic                  lat_we, lat_err;
   logic [ADDR_WIDTH-1:0] lat_idx;
   logic [SEL_W-1:0]      lat_sel;
   logic [DATA_WIDTH-1:0] lat_dat;

   logic                  cur_we, cur_err;
   logic [ADDR_WIDTH-1:0] cur_idx;
   logic [SEL_W-1:0]      cur_sel;
   logic [DATA_WIDTH-1:0] cur_dat;

   logic                  ack_q, err_q, dat_vld_q;
   logic                  mem_en;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign req = wb.wb_cyc_i & wb.wb_stb_i;

   // With no wait states the response edge is the accept edge, so the live bus
   // request is used in IDLE and the latched copy everywhere else.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_we  = wb.wb_we_i;
         cur_err = adr_decode_err(wb.wb_adr_i, ADDR_WIDTH);
         cur_idx = wb.wb_adr_i[ADDR_WIDTH+1:2];
         cur_sel = wb.wb_sel_i;
         cur_dat = wb.wb_dat_i;
      end else begin
         cur_we  = lat_we;
         cur_err = lat_err;
         cur_idx = lat_idx;
         cur_sel = lat_sel;
         cur_dat = lat_dat;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      fire    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  fire    = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (!req) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               fire    = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat_vld_q <= 1'b0;
         lat_we    <= 1'b0;
         lat_err   <= 1'b0;
         lat_idx   <= '0;
         lat_sel   <= '0;
         lat_dat   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= fire & ~cur_err;
         err_q   <= fire & cur_err;
         if (fire && !cur_err && !cur_we) begin
            dat_vld_q <= 1'b1;
         end
         if (accept) begin
            lat_we  <= cur_we;
            lat_err <= cur_err;
            lat_idx <= cur_idx;
            lat_sel <= cur_sel;
            lat_dat <= cur_dat;
         end
      end
   end

   // The array has no reset, so keep it from being touched while rst is held low.
   assign mem_en = fire & ~cur_err & rst;

   sram_1rw #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sram (
      .clk   (clk),
      .en    (mem_en),
      .we    (cur_we),
      .be    (cur_sel),
      .addr  (cur_idx),
      .wdata (cur_dat),
      .rdata (mem_rdata)
   );

   // Read data reads as zero from reset until the first successful read.
   assign wb.wb_dat_o = dat_vld_q ? mem_rdata : '0;
   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;

endmodule

// File: tb/tb_wbs_sram_responder.sv
// Bench for wbs_sram_responder: one instance without and one with 3 wait states,
// checked against an array model of memory and the bus rules.
module tb_wbs_sram_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wbs_sram_responder_if #(.DATA_WIDTH(32)) bus0 ();
   wbs_sram_responder_if #(.DATA_WIDTH(32)) bus3 ();

   wbs_sram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
      .clk (clk), .rst (rst), .wb (bus0)
   );
   wbs_sram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (
      .clk (clk), .rst (rst), .wb (bus3)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] mem_m  [2][1024];
   logic [31:0] last_m [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input int d, input logic c, input logic s, input logic we,
                        input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
      if (d == 0) begin
         bus0.wb_cyc_i = c; bus0.wb_stb_i = s; bus0.wb_we_i = we;
         bus0.wb_adr_i = adr; bus0.wb_sel_i = sel; bus0.wb_dat_i = dat;
      end else begin
         bus3.wb_cyc_i = c; bus3.wb_stb_i = s; bus3.wb_we_i = we;
         bus3.wb_adr_i = adr; bus3.wb_sel_i = sel; bus3.wb_dat_i = dat;
      end
   endtask

   task automatic peek(input int d, output logic a, output logic e, output logic [31:0] q);
      if (d == 0) begin
         a = bus0.wb_ack_o; e = bus0.wb_err_o; q = bus0.wb_dat_o;
      end else begin
         a = bus3.wb_ack_o; e = bus3.wb_err_o; q = bus3.wb_dat_o;
      end
   endtask

   // One full classic cycle, starting and ending just after a falling edge.
   task automatic txn(input int d, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat, output logic [31:0] rd);
      logic        a, e, exp_err;
      logic [31:0] exp_dat;
      logic [9:0]  idx;
      int          lat;
      exp_err = (adr[1:0] != 2'b00) || (adr >= 32'h0000_1000);
      idx     = adr[11:2];
      drive(d, 1'b1, 1'b1, we, adr, sel, dat);
      @(posedge clk);
      a = 1'b0; e = 1'b0; rd = '0; lat = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         peek(d, a, e, rd);
         if (a || e) begin
            lat = k;
            break;
         end
      end
      drive(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      check("latency", 32'(lat), (d == 0) ? 32'd1 : 32'd4);
      check("ack", 32'(a), 32'(!exp_err));
      check("err", 32'(e), 32'(exp_err));
      exp_dat = (!exp_err && !we) ? mem_m[d][idx] : last_m[d];
      check("dat_o", rd, exp_dat);
      last_m[d] = exp_dat;
      if (!exp_err && we) begin
         for (int b = 0; b < 4; b++) begin
            if (sel[b]) mem_m[d][idx][8*b +: 8] = dat[8*b +: 8];
         end
      end
      @(negedge clk);
      peek(d, a, e, rd);
      check("one_pulse", 32'({a, e}), 32'd0);
   endtask

   // Request on the 3-wait-state instance withdrawn before the response edge k.
   task automatic abort_txn(input logic we, input logic [31:0] adr, input int k);
      logic        a, e, any;
      logic [31:0] q;
      drive(1, 1'b1, 1'b1, we, adr, 4'hF, $urandom());
      @(posedge clk);
      repeat (k - 1) @(posedge clk);
      @(negedge clk);
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      any = 1'b0;
      q   = '0;
      repeat (6) begin
         @(negedge clk);
         peek(1, a, e, q);
         any = any | a | e;
      end
      check("abort_quiet", 32'(any), 32'd0);
      check("abort_dat", q, last_m[1]);
   endtask

   task automatic check_zero(input string tag, input int d);
      logic        a, e;
      logic [31:0] q;
      peek(d, a, e, q);
      check(tag, {a, e, q[29:0]} | {2'b00, 30'(q[31:30] != 2'b00)}, 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic        a, e;
      logic [31:0] rd, adr;
      int unsigned idx;

      rst = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      last_m[0] = '0;
      last_m[1] = '0;
      for (int i = 0; i < 1024; i++) begin
         mem_m[0][i] = '0;
         mem_m[1][i] = '0;
      end

      // Reset values, during reset and on the first cycle after release
      repeat (3) @(negedge clk);
      check_zero("rst_hold0", 0);
      check_zero("rst_hold3", 1);
      rst = 1'b1;
      @(negedge clk);
      check_zero("rst_rel0", 0);
      check_zero("rst_rel3", 1);

      // Seed the word pool used by the rest of the run
      for (int d = 0; d < 2; d++) begin
         for (int w = 0; w < 17; w++) begin
            idx = (w == 16) ? 32'd1023 : 32'(w);
            txn(d, 1'b1, idx << 2, 4'hF, $urandom() | 32'h1, rd);
         end
      end

      // Full-word write/read with no wait states
      txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd);
      txn(0, 1'b0, 32'h10, 4'h0, 32'h0, rd);
      check("rw_deadbeef", rd, 32'hDEADBEEF);

      // Byte lanes, including an all-lanes-off write
      txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, rd);
      txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd);
      txn(0, 1'b1, 32'h20, 4'b0000, 32'h99999999, rd);
      txn(0, 1'b0, 32'h20, 4'h0, 32'h0, rd);
      check("byte_lanes", rd, 32'h11BB33DD);

      // Stb held high: acks only every other cycle
      drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
      @(posedge clk);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         peek(0, a, e, rd);
         check("b2b_ack", 32'(a), 32'(k % 2));
      end
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      last_m[0] = mem_m[0][4];
      check("b2b_dat", rd, mem_m[0][4]);
      @(negedge clk);

      // Decode errors, writes that must not alias, and the highest valid word
      txn(0, 1'b0, 32'h2, 4'hF, 32'h0, rd);
      txn(0, 1'b0, 32'h1000, 4'hF, 32'h0, rd);
      txn(0, 1'b1, 32'h1000, 4'hF, 32'hBAD0BAD0, rd);
      txn(0, 1'b1, 32'h12, 4'hF, 32'hBAD1BAD1, rd);
      txn(0, 1'b0, 32'hFFC, 4'h0, 32'h0, rd);
      txn(0, 1'b0, 32'h0, 4'h0, 32'h0, rd);
      txn(0, 1'b0, 32'h10, 4'h0, 32'h0, rd);
      txn(1, 1'b0, 32'hFFE, 4'h0, 32'h0, rd);
      txn(1, 1'b0, 32'hFFC, 4'h0, 32'h0, rd);

      // Wait states and aborted cycles
      txn(1, 1'b0, 32'h0, 4'h0, 32'h0, rd);
      abort_txn(1'b0, 32'h4, 3);
      txn(1, 1'b0, 32'h0, 4'h0, 32'h0, rd);
      for (int n = 0; n < 6; n++) begin
         adr = 32'($urandom_range(0, 15)) << 2;
         abort_txn($urandom_range(0, 1) == 1, adr, int'($urandom_range(1, 3)));
         txn(1, 1'b0, adr, 4'h0, 32'h0, rd);
      end

      // Reset in the middle of a waiting write
      txn(1, 1'b1, 32'h8, 4'hF, 32'h12345678, rd);
      txn(1, 1'b0, 32'h8, 4'h0, 32'h0, rd);
      drive(1, 1'b1, 1'b1, 1'b1, 32'h8, 4'hF, 32'h00000055);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      #1;
      check_zero("async_rst3", 1);
      check_zero("async_rst0", 0);
      @(negedge clk);
      rst = 1'b1;
      last_m[0] = '0;
      last_m[1] = '0;
      @(negedge clk);
      check_zero("post_rst3", 1);
      txn(1, 1'b0, 32'h8, 4'h0, 32'h0, rd);
      check("rst_keep", rd, 32'h12345678);

      // Randomised mix of good, misaligned and out-of-range cycles
      for (int n = 0; n < 80; n++) begin
         int d;
         d   = int'($urandom_range(0, 1));
         idx = ($urandom_range(0, 7) == 0) ? 32'd1023 : $urandom_range(0, 15);
         case ($urandom_range(0, 9))
            0:       adr = (idx << 2) | $urandom_range(1, 3);
            1:       adr = 32'h1000 + (idx << 2);
            2:       adr = 32'h8000_0000 | (idx << 2);
            default: adr = idx << 2;
         endcase
         txn(d, $urandom_range(0, 1) == 1, adr, 4'($urandom()), $urandom(), rd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
